tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note FIFO plus PLAY/GAP playback sequencer driving the tone generator's note select and enable.
// Define TONE_SEQ_LOOP_EN to add the loop input that recirculates played entries to the FIFO tail.
module tone_sequencer #(
    parameter int DEPTH     = 8,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic                     inclk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_note,
    input  logic [7:0]               wr_dur,
    input  logic                     pause,
    input  logic                     stop,
`ifdef TONE_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic [2:0]               note_sel,
    output logic                     tone_en,
    output logic                     busy,
    output logic                     note_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 2);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [2:0]    r_note_sel;
    logic          r_tone_en;
    logic          r_busy;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_dur_cnt;
    logic [GW-1:0] r_gap_cnt;

    logic [10:0]   w_head;
    logic [10:0]   w_wr_data;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_recirc;
    logic          w_wr_en;
    logic          w_tick;
    logic          w_play_end;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !pause && !stop;

`ifdef TONE_SEQ_LOOP_EN
    assign w_recirc = w_pop && loop;
`else
    assign w_recirc = 1'b0;
`endif

    // Recirculation owns the tail write port in the pop cycle, so external writes are refused.
    assign wr_ready  = !w_full && !stop && !w_recirc;
    assign w_push    = wr_valid && wr_ready;
    assign w_wr_en   = w_push || w_recirc;
    assign w_wr_data = w_recirc ? w_head : {wr_note, wr_dur};

    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_play_end = (r_state == S_PLAY) && !pause && w_tick && (r_dur_cnt == 8'd1);

    assign note_sel   = r_note_sel;
    assign tone_en    = r_tone_en && !pause;
    assign busy       = r_busy;
    assign note_done  = w_play_end && !stop && !rst;
    assign fifo_count = r_count;

    always_ff @(posedge inclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge inclk) begin
        if (rst || stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push && !w_recirc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge inclk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_note_sel <= 3'd0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_presc    <= '0;
            r_dur_cnt  <= 8'd0;
            r_gap_cnt  <= '0;
        end else if (stop) begin
            r_state   <= S_IDLE;
            r_tone_en <= 1'b0;
            r_busy    <= 1'b0;
            r_presc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_note_sel <= w_head[10:8];
                        r_dur_cnt  <= (w_head[7:0] == 8'd0) ? 8'd1 : w_head[7:0];
                        r_presc    <= '0;
                        r_state    <= S_PLAY;
                        r_tone_en  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (w_tick) begin
                            r_presc   <= '0;
                            r_dur_cnt <= r_dur_cnt - 8'd1;
                            if (r_dur_cnt == 8'd1) begin
                                r_tone_en <= 1'b0;
                                if (GAP_TICKS > 0) begin
                                    r_state   <= S_GAP;
                                    r_gap_cnt <= GW'(GAP_TICKS);
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!pause) begin
                        if (w_tick) begin
                            r_presc   <= '0;
                            r_gap_cnt <= r_gap_cnt - GW'(1);
                            if (r_gap_cnt == GW'(1)) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer (DEPTH=4, TICK_DIV=4, GAP_TICKS=1): note table, scoreboard of expected notes,
// and hand-written sequences for gap timing, full FIFO, pause, stop and reset.
module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_note = 3'd0;
    logic [7:0] wr_dur = 8'd0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif
    logic [2:0] note_sel;
    logic       tone_en;
    logic       busy;
    logic       note_done;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    tone_sequencer #(
        .DEPTH     (4),
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) dut (
        .inclk      (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_note    (wr_note),
        .wr_dur     (wr_dur),
        .pause      (pause),
        .stop       (stop),
`ifdef TONE_SEQ_LOOP_EN
        .loop       (loop),
`endif
        .note_sel   (note_sel),
        .tone_en    (tone_en),
        .busy       (busy),
        .note_done  (note_done),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [2:0] note;
        int         hi;
    } exp_t;

    typedef struct {
        logic [2:0] note;
        logic [7:0] dur;
        int         hi;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   hi_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Every expected note_done pops one scoreboard entry; audible cycles are counted since the last one.
    always @(negedge clk) begin
        if (tone_en) hi_cnt++;
        if (note_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_note_done: got note=%0d, expected no note", note_sel);
            end else begin
                mon_e = sb.pop_front();
                chk("note_sel_at_done", 32'(note_sel), 32'(mon_e.note));
                chk("audible_cycles", hi_cnt, mon_e.hi);
            end
            $display("note_done note=%0d high=%0d", note_sel, hi_cnt);
            hi_cnt = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push_note(input logic [2:0] n, input logic [7:0] d, input int hi, input logic acc);
        wr_valid = 1'b1;
        wr_note  = n;
        wr_dur   = d;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(acc));
        $display("push note=%0d dur=%0d ready=%0b", n, d, wr_ready);
        if (acc && hi > 0) sb.push_back('{note: n, hi: hi});
        nxt();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rise(input string nm);
        int n = 0;
        while (!tone_en && n < 50) begin
            nxt();
            n++;
        end
        chk(nm, 32'(tone_en), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!note_done && n < 200) begin
            nxt();
            n++;
        end
        chk(nm, 32'(note_done), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(busy == 1'b0 && fifo_count == 3'd0) && n < 600) begin
            nxt();
            n++;
        end
        chk(nm, 32'(busy), 32'd0);
        chk({nm, "_all_played"}, sb.size(), 32'd0);
    endtask

    initial begin
        logic [12:0] pat;
        logic [12:0] exp_pat;
        int          n;

        vecs[0] = '{note: 3'd1, dur: 8'd2, hi: 8};
        vecs[1] = '{note: 3'd5, dur: 8'd0, hi: 4};
        vecs[2] = '{note: 3'd7, dur: 8'd1, hi: 4};
        vecs[3] = '{note: 3'd0, dur: 8'd4, hi: 16};
        vecs[4] = '{note: 3'd6, dur: 8'd3, hi: 12};

        repeat (3) nxt();
        rst = 1'b0;
        #1;
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_tone_en", 32'(tone_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_note_done", 32'(note_done), 32'd0);
        chk("rst_note_sel", 32'(note_sel), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single note: fetch cycle, 12 audible cycles, 4-cycle gap, back to idle.
        push_note(3'd2, 8'd3, 12, 1'b1);
        chk("fetch_busy", 32'(busy), 32'd0);
        chk("fetch_count", 32'(fifo_count), 32'd1);
        nxt();
        chk("play_busy", 32'(busy), 32'd1);
        chk("play_note_sel", 32'(note_sel), 32'd2);
        chk("play_tone_en", 32'(tone_en), 32'd1);
        chk("play_count", 32'(fifo_count), 32'd0);
        wait_done("t1_done");
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("gap_busy_silent", 32'({busy, tone_en}), 32'b10);
        end
        nxt();
        chk("after_gap_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            push_note(vecs[i].note, vecs[i].dur, vecs[i].hi, 1'b1);
            wait_idle("table_idle");
        end

        // Back-to-back: high 4, low 5 (gap plus fetch), high 4.
        push_note(3'd0, 8'd1, 4, 1'b1);
        push_note(3'd7, 8'd1, 4, 1'b1);
        wait_rise("b2b_rise");
        for (int i = 0; i < 13; i++) begin
            pat[i]     = tone_en;
            exp_pat[i] = (i < 4) || (i >= 9);
            if (i == 0) chk("b2b_first_sel", 32'(note_sel), 32'd0);
            if (i == 9) chk("b2b_second_sel", 32'(note_sel), 32'd7);
            if (i < 12) nxt();
        end
        chk("b2b_pattern", 32'(pat), 32'(exp_pat));
        wait_idle("b2b_idle");

        // Fill while paused: fifth write refused and never played.
        pause = 1'b1;
        push_note(3'd1, 8'd1, 4, 1'b1);
        push_note(3'd3, 8'd1, 4, 1'b1);
        push_note(3'd5, 8'd1, 4, 1'b1);
        push_note(3'd6, 8'd1, 4, 1'b1);
        push_note(3'd4, 8'd1, 4, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("paused_no_pop", 32'(busy), 32'd0);
        pause = 1'b0;
        wait_idle("full_idle");

        // Pause for 10 cycles from the second audible cycle of a dur=2 note.
        push_note(3'd3, 8'd2, 8, 1'b1);
        wait_rise("pause_rise");
        nxt();
        pause = 1'b1;
        #1;
        chk("pause_tone_en", 32'(tone_en), 32'd0);
        repeat (9) nxt();
        nxt();
        pause = 1'b0;
        #1;
        n = 12;
        while (!note_done && n < 60) begin
            nxt();
            n++;
        end
        chk("pause_done_cycle", n, 32'd18);
        wait_idle("pause_idle");

        // Stop mid-note with three entries queued, write attempted in the stop cycle.
        push_note(3'd1, 8'd3, 0, 1'b1);
        push_note(3'd2, 8'd3, 0, 1'b1);
        push_note(3'd3, 8'd3, 0, 1'b1);
        push_note(3'd4, 8'd3, 0, 1'b1);
        chk("pre_stop_count", 32'(fifo_count), 32'd3);
        chk("pre_stop_tone", 32'(tone_en), 32'd1);
        stop     = 1'b1;
        wr_valid = 1'b1;
        wr_note  = 3'd0;
        wr_dur   = 8'd1;
        #1;
        chk("stop_wr_ready", 32'(wr_ready), 32'd0);
        nxt();
        stop     = 1'b0;
        wr_valid = 1'b0;
        hi_cnt   = 0;
        chk("stop_count", 32'(fifo_count), 32'd0);
        chk("stop_tone_en", 32'(tone_en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_note_done", 32'(note_done), 32'd0);
        repeat (3) nxt();
        chk("stop_stays_idle", 32'({busy, fifo_count}), 32'd0);
        push_note(3'd4, 8'd1, 4, 1'b1);
        wait_idle("after_stop_idle");

        // Reset mid-note also clears note_sel.
        push_note(3'd6, 8'd2, 0, 1'b1);
        nxt();
        rst = 1'b1;
        nxt();
        rst    = 1'b0;
        hi_cnt = 0;
        chk("midrst_note_sel", 32'(note_sel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tone_en", 32'(tone_en), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);

`ifdef TONE_SEQ_LOOP_EN
        pause = 1'b1;
        push_note(3'd2, 8'd1, 4, 1'b1);
        push_note(3'd4, 8'd1, 4, 1'b1);
        push_note(3'd6, 8'd1, 4, 1'b1);
        sb.push_back('{note: 3'd2, hi: 4});
        sb.push_back('{note: 3'd4, hi: 4});
        sb.push_back('{note: 3'd6, hi: 4});
        loop  = 1'b1;
        pause = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_done("loop_done");
            chk("loop_count", 32'(fifo_count), 32'd3);
            nxt();
        end
        stop = 1'b1;
        nxt();
        stop   = 1'b0;
        loop   = 1'b0;
        hi_cnt = 0;
        chk("loop_stop_count", 32'(fifo_count), 32'd0);
        chk("loop_sb_empty", sb.size(), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
